// File: rtl/frame_buffer_dbl_if.sv
// Purpose: groups the rasterizer, swap-control and display-FIFO signals of the double-buffered frame buffer.
// Latency: none, this is wiring only.
// Backpressure: the pixel acknowledge and dvi_fifo_full are carried as plain signals.
interface frame_buffer_dbl_if #(
  parameter int COLOR_W = 3,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);
  logic               next_frame_switch;
  logic               rast_pixel_rdy;
  logic [COLOR_W-1:0] rast_color_input;
  logic [X_W-1:0]     rast_width;
  logic [Y_W-1:0]     rast_height;
  logic               rast_done;
  logic               read_rast_pixel_rdy;
  logic               dvi_fifo_full;
  logic [COLOR_W-1:0] dvi_color_out;
  logic               dvi_fifo_write_enable;
  logic               front_buf;
  logic               swap_pending;
  logic               clearing;

  // Rasterizer / clipping / display FIFO side.
  modport master (
    output next_frame_switch, rast_pixel_rdy, rast_color_input, rast_width, rast_height,
    output rast_done, dvi_fifo_full,
    input  read_rast_pixel_rdy, dvi_color_out, dvi_fifo_write_enable, front_buf,
    input  swap_pending, clearing
  );

  // Frame buffer side.
  modport slave (
    input  next_frame_switch, rast_pixel_rdy, rast_color_input, rast_width, rast_height,
    input  rast_done, dvi_fifo_full,
    output read_rast_pixel_rdy, dvi_color_out, dvi_fifo_write_enable, front_buf,
    output swap_pending, clearing
  );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Purpose: double-buffered frame store. Rasterizer writes the back buffer and raster scanout reads the front buffer.
// Latency: a pixel is acknowledged 1 cycle after acceptance, and scanout data is pushed 1 cycle after the read issues.
// Backpressure: scanout reads stall while dvi_fifo_full=1, and rasterizer writes stall during the post-swap clear.
module frame_buffer_dbl #(
  parameter int                 COLOR_W       = 3,
  parameter int                 H_RES         = 640,
  parameter int                 V_RES         = 480,
  parameter int                 X_W           = 10,
  parameter int                 Y_W           = 9,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR   = '0,
  parameter bit                 CLEAR_ON_SWAP = 1'b1
) (
  input logic              clk,
  input logic              rst,
  frame_buffer_dbl_if.slave bus
);

  localparam int FRAME = H_RES * V_RES;
  localparam int DEPTH = 2 * FRAME;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [AW-1:0]  FRAME_A  = AW'(FRAME);
  localparam logic [AW-1:0]  HRES_A   = AW'(H_RES);
  localparam logic [X_W:0]   HRES_X   = (X_W+1)'(H_RES);
  localparam logic [Y_W:0]   VRES_Y   = (Y_W+1)'(V_RES);
  localparam logic [X_W-1:0] SX_LAST  = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] SY_LAST  = Y_W'(V_RES - 1);
  localparam logic [CW-1:0]  CLR_LAST = CW'(FRAME - 1);

  typedef enum logic {IDLE_DRAW, CLEAR} state_t;
  state_t state, state_nxt;

  logic [COLOR_W-1:0] mem [DEPTH];

  logic [X_W-1:0]     sx;
  logic [Y_W-1:0]     sy;
  logic [CW-1:0]      clr_cnt;
  logic               done_flag;
  logic               issue, boundary, swap, accept, in_range, clr_we;
  logic               we;
  logic [AW-1:0]      waddr, raddr;
  logic [COLOR_W-1:0] wdata;

  // Buffer 1 sits directly above buffer 0 in the shared storage.
  function automatic logic [AW-1:0] pix_addr(input logic b, input logic [AW-1:0] offs);
    pix_addr = (b ? FRAME_A : '0) + offs;
  endfunction

  assign issue    = !bus.dvi_fifo_full;
  assign boundary = issue && (sx == SX_LAST) && (sy == SY_LAST);
  assign swap     = boundary && bus.swap_pending && done_flag;
  assign accept   = bus.rast_pixel_rdy && !bus.clearing && !bus.read_rast_pixel_rdy;
  assign in_range = ({1'b0, bus.rast_width} < HRES_X) && ({1'b0, bus.rast_height} < VRES_Y);
  assign raddr    = pix_addr(bus.front_buf, AW'(sy) * HRES_A + AW'(sx));
  assign bus.clearing = (state == CLEAR);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE_DRAW;
    else     state <= state_nxt;
  end

  // FSM next state: a swap starts the clear, and the last clear address returns to drawing.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    case (state)
      IDLE_DRAW: if (swap && CLEAR_ON_SWAP) state_nxt = CLEAR;
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = IDLE_DRAW;
      end
      default: state_nxt = IDLE_DRAW;
    endcase
  end

  // The single write port is owned by the clear while it runs, otherwise by the rasterizer.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = CLEAR_COLOR;
    if (clr_we) begin
      we    = 1'b1;
      waddr = pix_addr(!bus.front_buf, AW'(clr_cnt));
    end else if (accept && in_range) begin
      we    = 1'b1;
      waddr = pix_addr(!bus.front_buf, AW'(bus.rast_height) * HRES_A + AW'(bus.rast_width));
      wdata = bus.rast_color_input;
    end
  end

  // Clear address counter walks the back buffer once per clear.
  always_ff @(posedge clk) begin
    if (rst)                    clr_cnt <= '0;
    else if (state == CLEAR)    clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
  end

  // Raster scan position advances only when a read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (issue) begin
      if (sx == SX_LAST) begin
        sx <= '0;
        sy <= (sy == SY_LAST) ? '0 : sy + 1'b1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  // Swap bookkeeping: a new request in the swap cycle survives the swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.front_buf    <= 1'b0;
      bus.swap_pending <= 1'b0;
      done_flag        <= 1'b0;
    end else begin
      if (swap) bus.front_buf <= ~bus.front_buf;
      if (bus.next_frame_switch) bus.swap_pending <= 1'b1;
      else if (swap)             bus.swap_pending <= 1'b0;
      if (swap)                                done_flag <= 1'b0;
      else if (bus.rast_done && !bus.clearing) done_flag <= 1'b1;
    end
  end

  // Storage write, which is not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data, FIFO push strobe and pixel acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dvi_color_out         <= '0;
      bus.dvi_fifo_write_enable <= 1'b0;
      bus.read_rast_pixel_rdy   <= 1'b0;
    end else begin
      if (issue) bus.dvi_color_out <= mem[raddr];
      bus.dvi_fifo_write_enable <= issue;
      bus.read_rast_pixel_rdy   <= accept;
    end
  end

endmodule
